// File: rtl/vga_draw_arbiter_pkg.sv
// Shared widths, screen limits and FSM state type for the VGA draw arbiter.
package vga_draw_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned C_W      = 3;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [C_W-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/vga_draw_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_onehot_c,
  output logic [IDX_W-1:0] win_idx_c,
  output logic             any_req_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    win_onehot_c = '0;
    win_idx_c    = '0;
    any_req_c    = 1'b0;
    cand         = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NREQ);
      if (!any_req_c && req[cand]) begin
        any_req_c          = 1'b1;
        win_idx_c          = cand;
        win_onehot_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA plot port; sweeps a BOX_W x BOX_H box per grant.
// Optional CLIP_EN macro suppresses plots that fall off the 160x120 screen.
module vga_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BOX_W = 10,
  parameter int unsigned BOX_H = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*X_W-1:0] req_x,
  input  logic [NREQ*Y_W-1:0] req_y,
  input  logic [NREQ*C_W-1:0] req_colour,
  input  logic [NREQ-1:0]   req_erase,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [C_W-1:0]    vga_colour,
  output logic              vga_plot,
  output logic              busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CX_W  = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int unsigned CY_W  = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [X_W-1:0]   base_x_q, base_x_d;
  logic [Y_W-1:0]   base_y_q, base_y_d;
  logic [C_W-1:0]   colour_q, colour_d;
  logic [CX_W-1:0]  cx_q, cx_d;
  logic [CY_W-1:0]  cy_q, cy_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [X_W-1:0]   vga_x_q, vga_x_d;
  logic [Y_W-1:0]   vga_y_q, vga_y_d;
  logic [C_W-1:0]   vga_colour_q, vga_colour_d;
  logic             vga_plot_q, vga_plot_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [C_W-1:0]   sel_colour;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req          (req),
    .ptr          (ptr_q),
    .win_onehot_c (win_onehot),
    .win_idx_c    (win_idx),
    .any_req_c    (any_req)
  );

  // Pull the current winner's fields out of the packed request buses.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        sel_x      = req_x[i*X_W +: X_W];
        sel_y      = req_y[i*Y_W +: Y_W];
        sel_colour = req_erase[i] ? COLOUR_BLACK : req_colour[i*C_W +: C_W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    colour_d     = colour_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    grant_d      = grant_q;
    done_d       = '0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d    = win_idx;
          base_x_d = sel_x;
          base_y_d = sel_y;
          colour_d = sel_colour;
          grant_d  = win_onehot;
          cx_d     = '0;
          cy_d     = '0;
          state_d  = S_SWEEP;
        end
      end
      S_SWEEP: begin
        vga_x_d      = base_x_q + X_W'(cx_q);
        vga_y_d      = base_y_q + Y_W'(cy_q);
        vga_colour_d = colour_q;
`ifdef CLIP_EN
        vga_plot_d   = (vga_x_d < X_W'(SCREEN_W)) && (vga_y_d < Y_W'(SCREEN_H));
`else
        vga_plot_d   = 1'b1;
`endif
        if (cx_q == CX_W'(BOX_W - 1)) begin
          cx_d = '0;
          if (cy_q == CY_W'(BOX_H - 1)) begin
            state_d = S_DONE;
          end else begin
            cy_d = cy_q + CY_W'(1);
          end
        end else begin
          cx_d = cx_q + CX_W'(1);
        end
      end
      S_DONE: begin
        grant_d       = '0;
        done_d[win_q] = 1'b1;
        ptr_d         = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      base_x_q     <= '0;
      base_y_q     <= '0;
      colour_q     <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      colour_q     <= colour_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter: directed table, multi-cycle sequences, random rounds.
module tb_vga_draw_arbiter;

  localparam int BOX_W = 10;
  localparam int BOX_H = 10;
  localparam int NPIX  = BOX_W * BOX_H;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  req_erase;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;

  logic [7:0] bx [4];
  logic [6:0] by [4];
  logic [2:0] bc [4];
  bit         be [4];

  assign req_x      = {bx[3], bx[2], bx[1], bx[0]};
  assign req_y      = {by[3], by[2], by[1], by[0]};
  assign req_colour = {bc[3], bc[2], bc[1], bc[0]};
  assign req_erase  = {be[3], be[2], be[1], be[0]};

  vga_draw_arbiter #(.NREQ(4), .BOX_W(BOX_W), .BOX_H(BOX_H)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .req_erase  (req_erase),
    .grant      (grant),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int m_ptr  = 0;
  int last_g = 0;
  int last_d = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         w;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    bit         e;
    logic [7:0] fx;
    logic [6:0] fy;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [2:0] col;
    int         plots;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arbitration: first pending requester at or after the pointer.
  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[2'((p + k) % 4)]) return (p + k) % 4;
    end
    return 0;
  endfunction

  task automatic set_params(input int i, input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c, input bit e);
    bx[i] = x; by[i] = y; bc[i] = c; be[i] = e;
  endtask

  // Follow one complete service of requester w and compare every cycle against the model.
  task automatic serve(input int w, input logic [3:0] drop_mask, output int plots,
                       output logic [7:0] fx, output logic [6:0] fy,
                       output logic [7:0] lx, output logic [6:0] ly, output logic [2:0] lc);
    logic [3:0] oh;
    logic [7:0] ex0, ex;
    logic [6:0] ey0, ey;
    logic [2:0] ecol;
    logic       eplot;
    int         t;
    plots = 0; fx = '0; fy = '0; lx = '0; ly = '0; lc = '0;
    oh   = 4'b0001 << w;
    ex0  = bx[w];
    ey0  = by[w];
    ecol = be[w] ? 3'd0 : bc[w];
    t = 0;
    while (grant === 4'b0000 && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (grant === 4'b0000) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_timeout: no grant for requester %0d within 20 cycles", w);
      return;
    end
    last_g = cyc;
    chk($sformatf("grant_r%0d", w), {grant, done, busy, vga_plot}, {oh, 4'b0, 1'b1, 1'b0});
    // scramble the winner's inputs; the service in flight must ignore them
    bx[w] = 8'($urandom); by[w] = 7'($urandom); bc[w] = 3'($urandom); be[w] = 1'($urandom);
    for (int k = 0; k < NPIX; k++) begin
      @(negedge clock);
      ex = ex0 + 8'(k % BOX_W);
      ey = ey0 + 7'(k / BOX_W);
`ifdef CLIP_EN
      eplot = (ex < 8'd160) && (ey < 7'd120);
`else
      eplot = 1'b1;
`endif
      chk($sformatf("pixel%0d_r%0d", k, w),
          {grant, done, busy, vga_plot, vga_x, vga_y, vga_colour},
          {oh, 4'b0, 1'b1, eplot, ex, ey, ecol});
      if (vga_plot === 1'b1) begin
        if (plots == 0) begin fx = vga_x; fy = vga_y; end
        lx = vga_x; ly = vga_y; lc = vga_colour;
        plots++;
      end
    end
    @(negedge clock);
    chk($sformatf("done_r%0d", w), {done, grant, busy, vga_plot}, {oh, 4'b0, 1'b0, 1'b0});
    last_d = cyc;
    m_ptr  = (w + 1) % 4;
    req    = req & ~drop_mask;
    @(negedge clock);
    chk($sformatf("done_clear_r%0d", w), {28'b0, done}, 64'd0);
  endtask

  vec_t       tv [5];
  int         plots, w, g0, d0, t;
  logic [7:0] fx, lx;
  logic [6:0] fy, ly;
  logic [2:0] lc;
  logic [3:0] mask;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tv[0] = '{0, 8'd14,  7'd99,  3'd7, 1'b0, 8'd14,  7'd99,  8'd23,  7'd108, 3'd7, 100};
    tv[1] = '{0, 8'd14,  7'd99,  3'd7, 1'b1, 8'd14,  7'd99,  8'd23,  7'd108, 3'd0, 100};
`ifdef CLIP_EN
    tv[2] = '{1, 8'd250, 7'd125, 3'd5, 1'b0, 8'd0,   7'd0,   8'd3,   7'd6,   3'd5, 28};
    tv[3] = '{3, 8'd155, 7'd115, 3'd2, 1'b0, 8'd155, 7'd115, 8'd159, 7'd119, 3'd2, 25};
`else
    tv[2] = '{1, 8'd250, 7'd125, 3'd5, 1'b0, 8'd250, 7'd125, 8'd3,   7'd6,   3'd5, 100};
    tv[3] = '{3, 8'd155, 7'd115, 3'd2, 1'b0, 8'd155, 7'd115, 8'd164, 7'd124, 3'd2, 100};
`endif
    tv[4] = '{2, 8'd0,   7'd0,   3'd4, 1'b0, 8'd0,   7'd0,   8'd9,   7'd9,   3'd4, 100};

    for (int i = 0; i < 4; i++) set_params(i, 8'd0, 7'd0, 3'd0, 1'b0);
    req   = 4'b0000;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_state", {grant, done, busy, vga_plot, vga_x, vga_y, vga_colour}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_no_req", {grant, done, busy, vga_plot}, 64'd0);

    // Directed single-requester table.
    for (int i = 0; i < 5; i++) begin
      set_params(tv[i].w, tv[i].x, tv[i].y, tv[i].c, tv[i].e);
      req[2'(tv[i].w)] = 1'b1;
      serve(pick(req, m_ptr), req, plots, fx, fy, lx, ly, lc);
      chk($sformatf("vec%0d_plots", i), 64'(plots), 64'(tv[i].plots));
      chk($sformatf("vec%0d_first", i), {fx, fy}, {tv[i].fx, tv[i].fy});
      chk($sformatf("vec%0d_last", i), {lx, ly, lc}, {tv[i].lx, tv[i].ly, tv[i].col});
    end

    // Two simultaneous requests: 0 then 2, next grant on the edge that clears done.
    set_params(0, 8'd20, 7'd30, 3'd1, 1'b0);
    set_params(2, 8'd40, 7'd50, 3'd6, 1'b0);
    req = 4'b0101;
    w = pick(req, m_ptr);
    serve(w, 4'b0001 << w, plots, fx, fy, lx, ly, lc);
    g0 = last_g; d0 = last_d;
    w = pick(req, m_ptr);
    serve(w, 4'b0001 << w, plots, fx, fy, lx, ly, lc);
    chk("pair_done_to_grant", 64'(last_g - d0), 64'd1);
    chk("pair_grant_spacing", 64'(last_g - g0), 64'd102);

    // Two requesters held continuously alternate.
    req = 4'b0011;
    for (int s = 0; s < 4; s++) begin
      w  = pick(req, m_ptr);
      g0 = last_g;
      serve(w, (s == 3) ? 4'b0011 : 4'b0000, plots, fx, fy, lx, ly, lc);
      if (s > 0) chk($sformatf("hold_spacing%0d", s), 64'(last_g - g0), 64'd102);
    end

    // Random rounds against the reference model.
    for (int r = 0; r < 8; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        if (mask[2'(i)]) set_params(i, 8'($urandom), 7'($urandom), 3'($urandom), 1'($urandom));
      req = mask;
      t = 0;
      while (req != 4'b0000 && t < 8) begin
        w = pick(req, m_ptr);
        serve(w, 4'b0001 << w, plots, fx, fy, lx, ly, lc);
        t++;
      end
    end

    // Reset mid-sweep: outputs clear at once, pointer returns to 0, no done.
    set_params(0, 8'd1, 7'd2, 3'd3, 1'b0);
    req = 4'b0001;
    serve(0, 4'b0001, plots, fx, fy, lx, ly, lc);
    set_params(3, 8'd60, 7'd70, 3'd5, 1'b0);
    req = 4'b1000;
    t = 0;
    while (grant === 4'b0000 && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("abort_grant", {28'b0, grant}, 64'h8);
    repeat (50) @(negedge clock);
    chk("abort_mid_sweep", {vga_plot, vga_x, vga_y}, {1'b1, 8'd69, 7'd74});
    reset = 1'b1;
    #1;
    chk("abort_outputs_zero", {grant, done, busy, vga_plot, vga_x, vga_y, vga_colour}, 64'd0);
    req = 4'b0000;
    m_ptr = 0;
    set_params(0, 8'd100, 7'd10, 3'd6, 1'b0);
    set_params(1, 8'd110, 7'd20, 3'd2, 1'b1);
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("abort_no_done%0d", i), {grant, done, vga_plot}, 64'd0);
    end
    reset = 1'b0;
    w = pick(req, m_ptr);
    serve(w, 4'b0001 << w, plots, fx, fy, lx, ly, lc);
    w = pick(req, m_ptr);
    serve(w, 4'b0001 << w, plots, fx, fy, lx, ly, lc);
    @(negedge clock);
    chk("final_idle", {grant, done, busy, vga_plot}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
